// File: rtl/spike_aer_encoder_pkg.sv
// Shared types and constants for the spike-to-AER encoder slice.
package spike_aer_encoder_pkg;

    localparam int unsigned AER_TS_W   = 16;
    localparam int unsigned AER_ADDR_W = 5;
    localparam int unsigned DROP_CNT_W = 16;

    // Event word layout for the default geometry: timestamp in the upper bits.
    typedef struct packed {
        logic [AER_TS_W-1:0]   ts;
        logic [AER_ADDR_W-1:0] addr;
    } aer_event_t;

    typedef enum logic {
        AER_IDLE,
        AER_SCAN
    } aer_state_t;

endpackage

// File: rtl/spike_aer_fifo.sv
// Synchronous event FIFO with show-ahead head output taken straight from the
// storage registers; push while full is accepted only together with a pop.
module spike_aer_fifo #(
    parameter int unsigned DATA_W = 21,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike vector to AER stream encoder: captures a nonzero spike vector with its
// tick, serialises set bits lowest-address-first into an event FIFO.
// Optional statistics ports (evt_cnt, max_occ) exist when SPIKE_AER_STATS_EN is defined.
module spike_aer_encoder
    import spike_aer_encoder_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 32,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TS_W        = AER_TS_W,
    localparam int unsigned ADDR_W     = $clog2(NUM_NEURONS),
    localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ADDR_W-1:0]      aer_addr,
    output logic [TS_W-1:0]        aer_ts,
    output logic                   busy,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_cnt
`ifdef SPIKE_AER_STATS_EN
    ,
    output logic [31:0]            evt_cnt,
    output logic [OCC_W-1:0]       max_occ
`endif
);

    localparam int unsigned EV_W = TS_W + ADDR_W;

    aer_state_t             state;
    aer_state_t             state_nxt;
    logic [NUM_NEURONS-1:0] pend;
    logic [NUM_NEURONS-1:0] pend_nxt;
    logic [NUM_NEURONS-1:0] pend_rest;
    logic [TS_W-1:0]        cap_ts;
    logic [TS_W-1:0]        cap_ts_nxt;
    logic [TS_W-1:0]        ts_ctr;
    logic [ADDR_W-1:0]      low_idx;
    logic                   spike_any;
    logic                   last_bit;
    logic                   can_push;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [OCC_W-1:0]       fifo_cnt;
    logic [EV_W-1:0]        head;

    assign spike_any = |spike_vec;
    // Clearing the lowest set bit is pend & (pend - 1); empty result marks the last event.
    assign pend_rest = pend & (pend - 1'b1);
    assign last_bit  = (pend_rest == '0);
    assign pop       = aer_valid && aer_ready;
    assign can_push  = !fifo_full || pop;
    assign aer_valid = !fifo_empty;
    assign {aer_ts, aer_addr} = head;

    // Priority encoder: scan high to low so the lowest set index wins.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            if (pend[NUM_NEURONS-1-i]) begin
                low_idx = ADDR_W'(NUM_NEURONS - 1 - i);
            end
        end
    end

    // Free-running tick counter, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_ctr <= '0;
        end else begin
            ts_ctr <= ts_ctr + 1'b1;
        end
    end

    // State register plus captured vector and its tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= AER_IDLE;
            pend   <= '0;
            cap_ts <= '0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            cap_ts <= cap_ts_nxt;
        end
    end

    // Next-state: capture in IDLE, clear one bit per accepted push in SCAN,
    // and chain straight into a new vector on the last-bit cycle.
    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        cap_ts_nxt = cap_ts;
        case (state)
            AER_IDLE: begin
                if (spike_any) begin
                    pend_nxt   = spike_vec;
                    cap_ts_nxt = ts_ctr;
                    state_nxt  = AER_SCAN;
                end
            end
            AER_SCAN: begin
                if (can_push) begin
                    pend_nxt = pend_rest;
                    if (last_bit) begin
                        if (spike_any) begin
                            pend_nxt   = spike_vec;
                            cap_ts_nxt = ts_ctr;
                        end else begin
                            state_nxt = AER_IDLE;
                        end
                    end
                end
            end
            default: state_nxt = AER_IDLE;
        endcase
    end

    // Outputs: busy flag, FIFO push strobe, and drop detection for vectors arriving mid-scan.
    always_comb begin
        busy = (state == AER_SCAN);
        push = (state == AER_SCAN) && can_push;
        drop = (state == AER_SCAN) && spike_any && !(can_push && last_bit);
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    spike_aer_fifo #(
        .DATA_W (EV_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({cap_ts, low_idx}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

`ifdef SPIKE_AER_STATS_EN
    // Handshake counter and peak FIFO occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
            max_occ <= '0;
        end else begin
            if (pop) begin
                evt_cnt <= evt_cnt + 1'b1;
            end
            if (fifo_cnt > max_occ) begin
                max_occ <= fifo_cnt;
            end
        end
    end
`else
    logic unused_occ;
    assign unused_occ = ^fifo_cnt;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed self-checking bench for spike_aer_encoder (default geometry 32/16/16).
module tb_spike_aer_encoder;

    logic        clk;
    logic        rst;
    logic [31:0] spike_vec;
    logic        aer_valid;
    logic        aer_ready;
    logic [4:0]  aer_addr;
    logic [15:0] aer_ts;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_cnt;
`ifdef SPIKE_AER_STATS_EN
    logic [31:0] evt_cnt;
    logic [4:0]  max_occ;
`endif

    int n_cmp;
    int n_fail;
    logic [15:0] tb_ts;

    spike_aer_encoder #(
        .NUM_NEURONS (32),
        .FIFO_DEPTH  (16),
        .TS_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spike_vec (spike_vec),
        .aer_valid (aer_valid),
        .aer_ready (aer_ready),
        .aer_addr  (aer_addr),
        .aer_ts    (aer_ts),
        .busy      (busy),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`ifdef SPIKE_AER_STATS_EN
        ,
        .evt_cnt   (evt_cnt),
        .max_occ   (max_occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tick: what the timestamp counter should read in the current cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 16'd1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        spike_vec = '0;
        aer_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic advance_to(input logic [15:0] target);
        for (int k = 0; k < 70000 && tb_ts != target; k++) tick();
        n_cmp++;
        if (tb_ts !== target) begin
            n_fail++;
            $display("FAIL advance_to: tick %0h reached, required %0h", tb_ts, target);
        end
    endtask

    task automatic get_word(output logic [4:0] a, output logic [15:0] t, output bit ok);
        ok = 1'b0;
        a  = '0;
        t  = '0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (aer_valid && aer_ready) begin
                a  = aer_addr;
                t  = aer_ts;
                ok = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        spike_vec = 32'hFFFF_FFFF;
        aer_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", aer_valid); end
        n_cmp++; if (aer_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d required 0", aer_addr); end
        n_cmp++; if (aer_ts !== 16'd0) begin n_fail++; $display("FAIL reset_ts: got %0h required 0", aer_ts); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt); end
    endtask

    task automatic test_single();
        bit quiet;
        do_reset();
        aer_ready = 1'b1;
        advance_to(16'd5);
        spike_vec = 32'h0000_0001;
        tick();
        spike_vec = '0;
        n_cmp++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: valid %b at ts 6, required 0", aer_valid); end
        tick();
        n_cmp++; if (aer_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: valid %b at ts 7, required 1", aer_valid); end
        n_cmp++; if (aer_addr !== 5'd0) begin n_fail++; $display("FAIL single_addr: got %0d required 0", aer_addr); end
        n_cmp++; if (aer_ts !== 16'd5) begin n_fail++; $display("FAIL single_ts: got %0h required 5", aer_ts); end
        quiet = 1'b1;
        repeat (6) begin
            tick();
            if (aer_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL single_extra: extra word seen, required none"); end
    endtask

    task automatic test_multi();
        logic [4:0] ea [3] = '{5'd0, 5'd4, 5'd31};
        do_reset();
        aer_ready = 1'b1;
        advance_to(16'd10);
        spike_vec = 32'h8000_0011;
        tick();
        spike_vec = '0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL multi_busy_11: got %b required 1", busy); end
        n_cmp++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL multi_valid_11: got %b required 0", aer_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (busy !== (i < 2)) begin n_fail++; $display("FAIL multi_busy[%0d]: got %b required %b", i, busy, (i < 2)); end
            n_cmp++; if (aer_valid !== 1'b1 || aer_addr !== ea[i] || aer_ts !== 16'd10) begin
                n_fail++;
                $display("FAIL multi_word[%0d]: got v=%b addr=%0d ts=%0h required v=1 addr=%0d ts=a", i, aer_valid, aer_addr, aer_ts, ea[i]);
            end
        end
        tick();
        n_cmp++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL multi_tail: valid %b required 0", aer_valid); end
    endtask

    task automatic test_backpressure();
        logic [4:0]  a;
        logic [15:0] t;
        bit          ok;
        rst       = 1'b1;
        aer_ready = 1'b0;
        spike_vec = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        spike_vec = '0;
        advance_to(16'd20);
        n_cmp++; if (aer_valid !== 1'b1 || aer_addr !== 5'd0 || aer_ts !== 16'd0) begin
            n_fail++; $display("FAIL bp_head: got v=%b addr=%0d ts=%0h required v=1 addr=0 ts=0", aer_valid, aer_addr, aer_ts);
        end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_stall_busy: got %b required 1", busy); end
        advance_to(16'd25);
        n_cmp++; if (aer_valid !== 1'b1 || aer_addr !== 5'd0) begin
            n_fail++; $display("FAIL bp_hold: got v=%b addr=%0d required v=1 addr=0", aer_valid, aer_addr);
        end
`ifdef SPIKE_AER_STATS_EN
        n_cmp++; if (max_occ !== 5'd16) begin n_fail++; $display("FAIL bp_max_occ: got %0d required 16", max_occ); end
`endif
        aer_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            get_word(a, t, ok);
            n_cmp++; if (!ok || a !== 5'(i) || t !== 16'd0) begin
                n_fail++; $display("FAIL bp_word[%0d]: got ok=%b addr=%0d ts=%0h required addr=%0d ts=0", i, ok, a, t, i);
            end
        end
        n_cmp++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_drained: got v=%b busy=%b required 0 0", aer_valid, busy);
        end
`ifdef SPIKE_AER_STATS_EN
        n_cmp++; if (evt_cnt !== 32'd32) begin n_fail++; $display("FAIL bp_evt_cnt: got %0d required 32", evt_cnt); end
`endif
    endtask

    task automatic test_drop();
        logic [4:0]  ea [4] = '{5'd0, 5'd1, 5'd2, 5'd5};
        logic [15:0] et [4] = '{16'd3, 16'd3, 16'd3, 16'd6};
        logic [4:0]  a;
        logic [15:0] t;
        bit          ok;
        do_reset();
        advance_to(16'd3);
        spike_vec = 32'h0000_0007;
        tick();
        spike_vec = 32'h0000_0100;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL drop_pre: overflow %b required 0", overflow); end
        tick();
        spike_vec = '0;
        tick();
        spike_vec = 32'h0000_0020;
        tick();
        spike_vec = '0;
        repeat (3) tick();
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %b required 1", overflow); end
        n_cmp++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d required 1", drop_cnt); end
        aer_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            get_word(a, t, ok);
            n_cmp++; if (!ok || a !== ea[i] || t !== et[i]) begin
                n_fail++; $display("FAIL drop_word[%0d]: got ok=%b addr=%0d ts=%0h required addr=%0d ts=%0h", i, ok, a, t, ea[i], et[i]);
            end
        end
        repeat (3) tick();
        n_cmp++; if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL drop_extra: valid %b required 0", aer_valid); end
        n_cmp++; if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL drop_hold: got cnt=%0d ovf=%b required 1 1", drop_cnt, overflow);
        end
    endtask

    task automatic test_wrap();
        logic [4:0]  a;
        logic [15:0] t;
        bit          ok;
        do_reset();
        advance_to(16'hFFFF);
        spike_vec = 32'h0000_0001;
        tick();
        spike_vec = 32'h0000_0002;
        tick();
        spike_vec = '0;
        repeat (3) tick();
        aer_ready = 1'b1;
        get_word(a, t, ok);
        n_cmp++; if (!ok || a !== 5'd0 || t !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_first: got ok=%b addr=%0d ts=%0h required addr=0 ts=ffff", ok, a, t);
        end
        get_word(a, t, ok);
        n_cmp++; if (!ok || a !== 5'd1 || t !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_second: got ok=%b addr=%0d ts=%0h required addr=1 ts=0", ok, a, t);
        end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_no_drop: got %0d required 0", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        do_reset();
        advance_to(16'd2);
        spike_vec = 32'h0000_0FFF;
        tick();
        spike_vec = 32'h0000_0001;
        tick();
        spike_vec = '0;
        advance_to(16'd11);
        n_cmp++; if (busy !== 1'b1 || aer_valid !== 1'b1 || drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL mid_pre: got busy=%b v=%b drop=%0d required 1 1 1", busy, aer_valid, drop_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_clear: got v=%b busy=%b required 0 0", aer_valid, busy);
        end
        n_cmp++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL mid_counters: got drop=%0d ovf=%b required 0 0", drop_cnt, overflow);
        end
`ifdef SPIKE_AER_STATS_EN
        n_cmp++; if (evt_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_evt_cnt: got %0d required 0", evt_cnt); end
`endif
        @(posedge clk);
        #1;
        rst       = 1'b0;
        aer_ready = 1'b1;
        quiet     = 1'b1;
        repeat (20) begin
            tick();
            if (aer_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL mid_stale: activity after reset, required none"); end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        spike_vec = '0;
        aer_ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_drop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
